// File: rtl/fft_feed_pkg.sv
// Shared types and defaults for the FFT frame feeder.
// The optional statistics counters are enabled by defining FFT_FEED_STAT_EN.
package fft_feed_pkg;

    localparam int unsigned DefDataW  = 24;
    localparam int unsigned DefLog2N  = 8;
    localparam int unsigned DefHop    = 256;
    localparam int unsigned DefTdataW = 32;
    localparam int unsigned CntW      = 16;

    typedef enum logic [1:0] {
        StCfg,
        StWait,
        StStream
    } feed_state_e;

endpackage

// File: rtl/fft_frame_feeder_if.sv
// Sample input and FFT stream bus for fft_frame_feeder.
// master = feeder side, slave = sample source / FFT sink side.
interface fft_frame_feeder_if #(
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned LOG2_N  = 8,
    parameter int unsigned TDATA_W = 32
);
    logic               s_valid;
    logic [DATA_W-1:0]  s_data;
    logic               m_tvalid;
    logic               m_tready;
    logic [TDATA_W-1:0] m_tdata;
    logic               m_tlast;
    logic [LOG2_N-1:0]  m_tuser;

    modport master (
        input  s_valid,
        input  s_data,
        input  m_tready,
        output m_tvalid,
        output m_tdata,
        output m_tlast,
        output m_tuser
    );

    modport slave (
        output s_valid,
        output s_data,
        output m_tready,
        input  m_tvalid,
        input  m_tdata,
        input  m_tlast,
        input  m_tuser
    );
endinterface

// File: rtl/fft_feed_ram.sv
// Simple dual-port sample RAM with a registered, enable-held read port.
// Only the read register is reset; the array contents are not.
module fft_feed_ram #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read data holds while re_i is low so a stalled beat stays stable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/fft_frame_feeder.sv
// Buffers audio samples in a 2N circular RAM and streams overlapping N-point frames to an FFT.
// Define FFT_FEED_STAT_EN to implement frame_cnt/drop_cnt; otherwise they read as zero.
module fft_frame_feeder
    import fft_feed_pkg::*;
#(
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned LOG2_N  = DefLog2N,
    parameter int unsigned HOP     = DefHop,
    parameter int unsigned TDATA_W = DefTdataW
) (
    input  logic                clk_50m,
    input  logic                rst,
    input  logic                enable,
    fft_frame_feeder_if.master  bus,
    output logic                cfg_tvalid,
    output logic                cfg_tdata,
    output logic                o_ovf,
    output logic [CntW-1:0]     frame_cnt,
    output logic [CntW-1:0]     drop_cnt
);
    localparam int unsigned N     = 2**LOG2_N;
    localparam int unsigned AddrW = LOG2_N + 1;
    localparam int unsigned PtrW  = LOG2_N + 2;

    localparam logic [PtrW-1:0]  NPtr    = PtrW'(N);
    localparam logic [PtrW-1:0]  Depth2N = PtrW'(2 * N);
    localparam logic [PtrW-1:0]  HopPtr  = PtrW'(HOP);
    localparam logic [AddrW-1:0] NAddr   = AddrW'(N);

    feed_state_e       state_q, state_d;
    logic [PtrW-1:0]   wp_q, wp_d, fs_q, fs_d, occ;
    logic [AddrW-1:0]  iss_q, iss_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic              m_tlast_q, m_tlast_d;
    logic [LOG2_N-1:0] m_tuser_q, m_tuser_d;
    logic              cfg_q, cfg_d;
    logic              ovf_q;
    logic              wr_en, drop, rd_en, advance, frame_end;
    logic [AddrW-1:0]  raddr;
    logic [DATA_W-1:0] rdata;

    // Occupancy always uses the pre-update fs, so a write at full is dropped
    // even when a frame retires in the same cycle.
    always_comb begin
        occ       = wp_q - fs_q;
        wr_en     = bus.s_valid && (occ < Depth2N);
        drop      = bus.s_valid && !wr_en;
        wp_d      = wr_en ? wp_q + PtrW'(1) : wp_q;
        frame_end = m_tvalid_q && bus.m_tready && m_tlast_q;
        advance   = !m_tvalid_q || bus.m_tready;
        raddr     = fs_q[AddrW-1:0] + iss_q;
    end

    always_comb begin
        state_d    = state_q;
        fs_d       = fs_q;
        iss_d      = iss_q;
        cfg_d      = 1'b0;
        rd_en      = 1'b0;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        m_tuser_d  = m_tuser_q;
        unique case (state_q)
            StCfg: begin
                cfg_d   = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                iss_d = '0;
                if (enable && (occ >= NPtr)) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                // Issue the next RAM read whenever the output slot frees up.
                if (advance) begin
                    if (iss_q != NAddr) begin
                        rd_en      = 1'b1;
                        m_tvalid_d = 1'b1;
                        m_tuser_d  = iss_q[LOG2_N-1:0];
                        m_tlast_d  = (iss_q == NAddr - AddrW'(1));
                        iss_d      = iss_q + AddrW'(1);
                    end else begin
                        m_tvalid_d = 1'b0;
                        m_tlast_d  = 1'b0;
                    end
                end
                if (frame_end) begin
                    fs_d    = fs_q + HopPtr;
                    state_d = StWait;
                end
            end
            default: state_d = StCfg;
        endcase
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q    <= StCfg;
            wp_q       <= '0;
            fs_q       <= '0;
            iss_q      <= '0;
            cfg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= '0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            fs_q       <= fs_d;
            iss_q      <= iss_d;
            cfg_q      <= cfg_d;
            ovf_q      <= ovf_q | drop;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tuser_q  <= m_tuser_d;
        end
    end

    fft_feed_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (AddrW)
    ) u_ram (
        .clk_i   (clk_50m),
        .rst_i   (rst),
        .we_i    (wr_en),
        .waddr_i (wp_q[AddrW-1:0]),
        .wdata_i (bus.s_data),
        .re_i    (rd_en),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

`ifdef FFT_FEED_STAT_EN
    logic [CntW-1:0] frame_cnt_q, drop_cnt_q;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (frame_end) frame_cnt_q <= frame_cnt_q + CntW'(1);
            if (drop)      drop_cnt_q  <= drop_cnt_q + CntW'(1);
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`else
    assign frame_cnt = '0;
    assign drop_cnt  = '0;
`endif

    assign bus.m_tvalid = m_tvalid_q;
    assign bus.m_tlast  = m_tlast_q;
    assign bus.m_tuser  = m_tuser_q;
    assign bus.m_tdata  = TDATA_W'($signed(rdata));
    assign cfg_tvalid   = cfg_q;
    assign cfg_tdata    = 1'b1;
    assign o_ovf        = ovf_q;
endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder with N=8, HOP=4.
// Counter expectations follow FFT_FEED_STAT_EN.
module tb_fft_frame_feeder;
    import fft_feed_pkg::*;

`ifdef FFT_FEED_STAT_EN
    localparam bit StatEn = 1'b1;
`else
    localparam bit StatEn = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  u;
        logic        l;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic            cfg_tvalid, cfg_tdata, o_ovf;
    logic [CntW-1:0] frame_cnt, drop_cnt;

    int    checks = 0;
    int    errors = 0;
    int    cfg_cnt = 0;
    bit    valid_seen = 1'b0;
    beat_t beats[$];

    fft_frame_feeder_if #(.DATA_W(24), .LOG2_N(3), .TDATA_W(32)) bus ();

    fft_frame_feeder #(
        .DATA_W  (24),
        .LOG2_N  (3),
        .HOP     (4),
        .TDATA_W (32)
    ) dut (
        .clk_50m    (clk),
        .rst        (rst),
        .enable     (enable),
        .bus        (bus),
        .cfg_tvalid (cfg_tvalid),
        .cfg_tdata  (cfg_tdata),
        .o_ovf      (o_ovf),
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Record accepted beats midway between edges, when inputs are settled.
    always @(negedge clk) begin
        if (cfg_tvalid) cfg_cnt++;
        if (bus.m_tvalid) valid_seen = 1'b1;
        if (bus.m_tvalid && bus.m_tready)
            beats.push_back('{d: bus.m_tdata, u: bus.m_tuser, l: bus.m_tlast});
    end

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_tready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        beats.delete();
        cfg_cnt = 0;
        valid_seen = 1'b0;
        rst = 1'b0;
    endtask

    task automatic write_one(input logic [23:0] v);
        bus.s_valid = 1'b1;
        bus.s_data = v;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic write_run(input int first, input int count);
        for (int i = 0; i < count; i++) write_one(24'(first + i));
    endtask

    task automatic wait_beats(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (beats.size() >= n) ok = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_tready = 1'b1;
        #3;
        checks++;
        if (bus.m_tvalid !== 1'b0 || cfg_tvalid !== 1'b0 || o_ovf !== 1'b0 ||
            bus.m_tlast !== 1'b0 || bus.m_tuser !== 3'd0 || bus.m_tdata !== 32'd0 ||
            frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: tvalid=%b cfg=%b ovf=%b tlast=%b tuser=%0d tdata=%h fc=%0d dc=%0d required all 0",
                     bus.m_tvalid, cfg_tvalid, o_ovf, bus.m_tlast, bus.m_tuser, bus.m_tdata,
                     frame_cnt, drop_cnt);
        end
        do_reset();
        enable = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        checks++;
        if (cfg_cnt !== 1) begin
            errors++;
            $display("FAIL cfg_pulse: cycles high=%0d required 1", cfg_cnt);
        end
        checks++;
        if (cfg_tdata !== 1'b1) begin
            errors++;
            $display("FAIL cfg_tdata: got %b required 1", cfg_tdata);
        end
        write_run(1, 7);
        repeat (4) begin
            @(posedge clk); #1;
        end
        checks++;
        if (valid_seen !== 1'b0) begin
            errors++;
            $display("FAIL early_valid: m_tvalid seen=%b with 7 samples, required 0", valid_seen);
        end
        write_one(24'd8);
        @(posedge clk); #1;
        checks++;
        if (bus.m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: m_tvalid=%b one cycle after trigger, required 0",
                     bus.m_tvalid);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== 32'd1 || bus.m_tuser !== 3'd0) begin
            errors++;
            $display("FAIL latency_first: tvalid=%b tdata=%h tuser=%0d required 1/00000001/0",
                     bus.m_tvalid, bus.m_tdata, bus.m_tuser);
        end
    endtask

    task automatic test_frames();
        bit ok;
        logic [31:0] exp_d;
        do_reset();
        enable = 1'b1;
        write_run(1, 16);
        wait_beats(24, ok);
        repeat (20) begin
            @(posedge clk); #1;
        end
        checks++;
        if (!ok || beats.size() != 24) begin
            errors++;
            $display("FAIL frame_count_beats: got %0d beats required 24", beats.size());
        end else begin
            for (int f = 0; f < 3; f++) begin
                for (int b = 0; b < 8; b++) begin
                    exp_d = 32'(4 * f + b + 1);
                    checks++;
                    if (beats[8*f+b].d !== exp_d || beats[8*f+b].u !== 3'(b) ||
                        beats[8*f+b].l !== (b == 7)) begin
                        errors++;
                        $display("FAIL frame_beat f%0d b%0d: got d=%0d u=%0d l=%b required d=%0d u=%0d l=%b",
                                 f, b, beats[8*f+b].d, beats[8*f+b].u, beats[8*f+b].l,
                                 exp_d, b, (b == 7));
                    end
                end
            end
        end
        checks++;
        if (frame_cnt !== (StatEn ? 16'd3 : 16'd0)) begin
            errors++;
            $display("FAIL frame_cnt: got %0d required %0d", frame_cnt, StatEn ? 3 : 0);
        end
    endtask

    task automatic test_sign_ext();
        bit ok;
        do_reset();
        enable = 1'b1;
        write_one(24'h800001);
        write_one(24'h7FFFFF);
        write_run(3, 6);
        wait_beats(2, ok);
        checks++;
        if (!ok || beats[0].d !== 32'hFF800001) begin
            errors++;
            $display("FAIL sign_ext_neg: got %h required FF800001", ok ? beats[0].d : 32'hx);
        end
        checks++;
        if (!ok || beats[1].d !== 32'h007FFFFF) begin
            errors++;
            $display("FAIL sign_ext_pos: got %h required 007FFFFF", ok ? beats[1].d : 32'hx);
        end
    endtask

    task automatic test_backpressure();
        bit found = 1'b0;
        bit ok;
        do_reset();
        write_run(1, 8);
        enable = 1'b1;
        for (int k = 0; k < 50 && !found; k++) begin
            @(posedge clk); #1;
            if (bus.m_tvalid && bus.m_tuser == 3'd4) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL stall_reach: beat 4 not seen, required within 50 cycles");
        end
        bus.m_tready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.m_tvalid !== 1'b1 || bus.m_tuser !== 3'd4 || bus.m_tdata !== 32'd5 ||
                bus.m_tlast !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold c%0d: tvalid=%b tuser=%0d tdata=%0d tlast=%b required 1/4/5/0",
                         c, bus.m_tvalid, bus.m_tuser, bus.m_tdata, bus.m_tlast);
            end
        end
        bus.m_tready = 1'b1;
        wait_beats(8, ok);
        repeat (5) begin
            @(posedge clk); #1;
        end
        checks++;
        if (!ok || beats.size() != 8) begin
            errors++;
            $display("FAIL stall_count: got %0d beats required 8", beats.size());
        end else begin
            for (int b = 0; b < 8; b++) begin
                checks++;
                if (beats[b].d !== 32'(b + 1) || beats[b].u !== 3'(b)) begin
                    errors++;
                    $display("FAIL stall_beat %0d: got d=%0d u=%0d required d=%0d u=%0d",
                             b, beats[b].d, beats[b].u, b + 1, b);
                end
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        do_reset();
        write_run(1, 16);
        checks++;
        if (o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_at_full: o_ovf=%b after 16 samples, required 0", o_ovf);
        end
        write_one(24'd17);
        checks++;
        if (o_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: o_ovf=%b required 1", o_ovf);
        end
        checks++;
        if (drop_cnt !== (StatEn ? 16'd1 : 16'd0)) begin
            errors++;
            $display("FAIL drop_cnt: got %0d required %0d", drop_cnt, StatEn ? 1 : 0);
        end
        checks++;
        if (valid_seen !== 1'b0) begin
            errors++;
            $display("FAIL ovf_no_stream: m_tvalid seen=%b with enable low, required 0",
                     valid_seen);
        end
        enable = 1'b1;
        wait_beats(8, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ovf_frame: got %0d beats required 8", beats.size());
        end else begin
            for (int b = 0; b < 8; b++) begin
                checks++;
                if (beats[b].d !== 32'(b + 1)) begin
                    errors++;
                    $display("FAIL ovf_beat %0d: got %0d required %0d", b, beats[b].d, b + 1);
                end
            end
        end
        checks++;
        if (o_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: o_ovf=%b required 1", o_ovf);
        end
    endtask

    task automatic test_reset_midframe();
        bit found = 1'b0;
        bit ok;
        do_reset();
        enable = 1'b1;
        write_run(1, 8);
        for (int k = 0; k < 50 && !found; k++) begin
            if (bus.m_tvalid && bus.m_tuser == 3'd3) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_reach: beat 3 not seen, required within 50 cycles");
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.m_tvalid !== 1'b0 || bus.m_tlast !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: tvalid=%b tlast=%b required 0/0",
                     bus.m_tvalid, bus.m_tlast);
        end
        @(posedge clk); #1;
        beats.delete();
        cfg_cnt = 0;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (cfg_cnt !== 1) begin
            errors++;
            $display("FAIL midreset_cfg: cycles high=%0d required 1", cfg_cnt);
        end
        write_run(101, 8);
        wait_beats(8, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midreset_frame: got %0d beats required 8", beats.size());
        end else begin
            for (int b = 0; b < 8; b++) begin
                checks++;
                if (beats[b].d !== 32'(101 + b) || beats[b].u !== 3'(b) ||
                    beats[b].l !== (b == 7)) begin
                    errors++;
                    $display("FAIL midreset_beat %0d: got d=%0d u=%0d l=%b required d=%0d u=%0d l=%b",
                             b, beats[b].d, beats[b].u, beats[b].l, 101 + b, b, (b == 7));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_sign_ext();
        test_backpressure();
        test_overflow();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_frame_feeder.md
FFT_FRAME_FEEDER -- requirements
Module: fft_frame_feeder

Interface
REQ-001 SHALL have parameter DATA_W, 24: audio sample width, two's complement.
REQ-002 SHALL have parameter LOG2_N, 8: log2 of FFT points N (N=256 default; legal 3..12).
REQ-003 SHALL have parameter HOP, 256: frame advance in samples, 1..N (HOP<N gives overlap).
REQ-004 SHALL have parameter TDATA_W, 32: FFT input beat width, TDATA_W>=DATA_W.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk_50m in 1 (sole clock); rst in 1 (asynchronous, active-high).
REQ-006 SHALL have port enable  in  1  frame start permitted.
REQ-007 SHALL have port s_valid  in  1  sample strobe (no backpressure).
REQ-008 SHALL have port s_data  in  DATA_W  sample.
REQ-009 SHALL have port m_tvalid  out  1  FFT data valid.
REQ-010 SHALL have port m_tready  in  1  FFT data ready.
REQ-011 SHALL have port m_tdata  out  TDATA_W  sign-extended sample.
REQ-012 SHALL have port m_tlast  out  1  last beat of frame.
REQ-013 SHALL have port m_tuser  out  LOG2_N  beat index in frame.
REQ-014 SHALL have port cfg_tvalid  out  1  FFT config strobe.
REQ-015 SHALL have port cfg_tdata  out  1  config word, constant 1 (forward FFT).
REQ-016 SHALL have port o_ovf  out  1  sticky overflow.
REQ-017 SHALL have port frame_cnt  out  16  frames sent.
REQ-018 SHALL have port drop_cnt  out  16  samples dropped.

Function
REQ-019 SHALL store samples in a circular buffer of depth 2N; write pointer wp and frame-start pointer fs are LOG2_N+2 bits wide; occupancy = wp-fs.
REQ-020 SHALL write s_data at wp and increment wp on s_valid when occupancy<2N; when occupancy==2N the sample is dropped, o_ovf sets, and drop_cnt increments.
REQ-021 SHALL use FSM CFG -> WAIT -> STREAM -> WAIT; exit from reset is to CFG.
REQ-022 SHALL assert cfg_tvalid for exactly one cycle in CFG, then go to WAIT.
REQ-023 SHALL leave WAIT for STREAM when enable==1 and occupancy>=N.
REQ-024 SHALL in STREAM emit N beats reading fs+0..fs+N-1 in order; m_tuser=beat index; m_tlast=1 only on index N-1.
REQ-025 SHALL assert first m_tvalid exactly 2 cycles after the WAIT->STREAM condition (1 cycle state change, 1 cycle registered RAM read).
REQ-026 SHALL complete a beat only on m_tvalid&&m_tready; while m_tvalid&&!m_tready, m_tdata, m_tuser and m_tlast hold stable and m_tvalid stays 1.
REQ-027 SHALL sustain one beat per cycle while m_tready==1 (read prefetch or skid, no bubbles within a frame).
REQ-028 SHALL on the accepting cycle of the m_tlast beat: fs+=HOP, frame_cnt+1 (wraps at 16 bits), return to WAIT; m_tvalid low the next cycle unless the next frame is already permitted.
REQ-029 SHALL finish the current frame if enable deasserts during STREAM.
REQ-030 SHALL evaluate occupancy before this cycle's fs update when a write coincides with frame end at full, so the sample is dropped.
REQ-031 SHALL drive m_tdata as s_data sign-extended to TDATA_W.
REQ-032 SHALL let drop_cnt wrap; o_ovf SHALL clear only on reset.

Reset
REQ-033 SHALL on rst clear immediately wp, fs, counters, o_ovf, m_tvalid, m_tlast, m_tuser, m_tdata and cfg_tvalid to 0, and force the state to CFG; buffer contents are not cleared.
REQ-034 SHALL discard any in-flight frame when rst asserts during STREAM; no m_tlast is issued for it.

Configuration
REQ-035 SHALL with macro FFT_FEED_STAT_EN defined implement frame_cnt and drop_cnt per REQ-020/REQ-028.
REQ-036 SHALL with FFT_FEED_STAT_EN undefined tie frame_cnt and drop_cnt to 0 and keep o_ovf.

Structure
REQ-037 SHALL take the FSM state enum, default parameter constants and the counter width (16) from shared package fft_feed_pkg.
REQ-038 SHALL instantiate sub-module fft_feed_ram: simple dual-port, 2N x DATA_W, 1-cycle registered read.

Verification (LOG2_N=3, HOP=4, DATA_W=24, TDATA_W=32)
REQ-039 SHALL cover: reset release -> cfg_tvalid high exactly 1 cycle; no m_tvalid before 8 samples written.
REQ-040 SHALL cover: samples 1..16, m_tready=1 -> frames {1..8},{5..12},{9..16}; m_tuser 0..7; m_tlast on values 8, 12, 16; frame_cnt=3.
REQ-041 SHALL cover: s_data=24'h800001 -> m_tdata=32'hFF800001.
REQ-042 SHALL cover: m_tready low 3 cycles at beat 4 -> beat 4 data/tuser held stable, no beat lost or duplicated.
REQ-043 SHALL cover: enable=0, write 17 samples -> 17th dropped, o_ovf=1, drop_cnt=1; then enable=1 -> first frame = samples 1..8.
REQ-044 SHALL cover: rst asserted at beat 3 of a frame -> m_tvalid=0 at once; after release, CFG pulse, then fresh frame from new samples.
